// File: rtl/demux_router.sv
// rtl/demux_router.sv - 1-to-4 demultiplexing router with a one-entry buffer per channel
module demux_router #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             S0,
  input  logic             S1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             V0,
  output logic             V1,
  output logic             V2,
  output logic             V3,
  input  logic             R0,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3,
  output logic [7:0]       CNT
);

  logic [1:0]       sel;
  logic [3:0]       r_vec;
  logic [3:0]       v_q;
  logic [WIDTH-1:0] y_q [4];
  logic [7:0]       cnt_q;
  logic             accept;

  assign sel   = {S1, S0};
  assign r_vec = {R3, R2, R1, R0};

  // A full channel can still accept when its own downstream drains this cycle.
  assign in_ready = (!v_q[sel] || r_vec[sel]) && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (sel == 2'(k))) begin
          y_q[k] <= D;
          v_q[k] <= 1'b1;
        end else if (v_q[k] && r_vec[k]) begin
          v_q[k] <= 1'b0;
        end
      end
      if (accept) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign Y0  = y_q[0];
  assign Y1  = y_q[1];
  assign Y2  = y_q[2];
  assign Y3  = y_q[3];
  assign V0  = v_q[0];
  assign V1  = v_q[1];
  assign V2  = v_q[2];
  assign V3  = v_q[3];
  assign CNT = cnt_q;

endmodule

// File: tb/tb_demux_router.sv
// tb/tb_demux_router.sv - self-checking bench for demux_router
module tb_demux_router;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] D;
  logic       S0, S1, in_valid;
  logic       in_ready;
  logic [7:0] Y0, Y1, Y2, Y3;
  logic       V0, V1, V2, V3;
  logic       R0, R1, R2, R3;
  logic [7:0] CNT;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_y [4];
  logic [3:0] m_v;
  int         m_cnt;
  logic       exp_ready, obs_ready;

  logic [7:0] y_obs [4];
  logic [3:0] v_obs;

  always #5 clk = ~clk;

  assign y_obs[0] = Y0;
  assign y_obs[1] = Y1;
  assign y_obs[2] = Y2;
  assign y_obs[3] = Y3;
  assign v_obs    = {V3, V2, V1, V0};

  demux_router #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .D(D), .S0(S0), .S1(S1),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .V0(V0), .V1(V1), .V2(V2), .V3(V3),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .CNT(CNT)
  );

  // One clock of stimulus from a negedge; reference model advances at the posedge.
  task automatic step(input logic r_in, input logic [7:0] d, input logic [1:0] s,
                      input logic valid, input logic [3:0] r);
    logic acc;
    rst = r_in; D = d; {S1, S0} = s; in_valid = valid; {R3, R2, R1, R0} = r;
    #1;
    obs_ready = in_ready;
    exp_ready = !r_in && (!m_v[s] || r[s]);
    acc = valid && exp_ready;
    @(posedge clk);
    if (r_in) begin
      m_v = 4'b0;
      m_cnt = 0;
      for (int k = 0; k < 4; k++) m_y[k] = 8'h00;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc && s == 2'(k)) begin
          m_y[k] = d;
          m_v[k] = 1'b1;
        end else if (r[k]) begin
          m_v[k] = 1'b0;
        end
      end
      if (acc) m_cnt = (m_cnt + 1) % 256;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 8'hFF, 2'd0, 1'b1, 4'h0);
    step(1'b1, 8'h55, 2'd3, 1'b1, 4'h0);
    total++;
    if (obs_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", obs_ready); end
    total++;
    if (v_obs !== 4'h0) begin bad++; $display("FAIL reset_v got=%h want=0", v_obs); end
    total++;
    if (CNT !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", CNT); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (y_obs[k] !== 8'h00) begin bad++; $display("FAIL reset_y%0d got=%h want=00", k, y_obs[k]); end
    end
    rst = 1'b0; in_valid = 1'b0; {R3, R2, R1, R0} = 4'h0;
    for (int s = 0; s < 4; s++) begin
      {S1, S0} = 2'(s);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready sel=%0d got=%b want=1", s, in_ready); end
    end
  endtask

  task automatic test_basic();
    step(1'b0, 8'hA5, 2'd2, 1'b1, 4'h0);
    total++;
    if (Y2 !== 8'hA5) begin bad++; $display("FAIL basic_y2 got=%h want=a5", Y2); end
    total++;
    if (v_obs !== 4'b0100) begin bad++; $display("FAIL basic_v got=%b want=0100", v_obs); end
    total++;
    if (CNT !== 8'd1) begin bad++; $display("FAIL basic_cnt got=%0d want=1", CNT); end
  endtask

  task automatic test_backpressure();
    step(1'b0, 8'h11, 2'd1, 1'b1, 4'h0);
    step(1'b0, 8'h3C, 2'd1, 1'b1, 4'h0);
    total++;
    if (obs_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_stall got=%b want=0", obs_ready); end
    total++;
    if (Y1 !== 8'h11 || V1 !== 1'b1 || CNT !== 8'd2) begin
      bad++; $display("FAIL bp_hold got=Y1 %h V1 %b CNT %0d want=11 1 2", Y1, V1, CNT);
    end
    step(1'b0, 8'h3C, 2'd1, 1'b1, 4'b0010);
    total++;
    if (obs_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_drain got=%b want=1", obs_ready); end
    total++;
    if (Y1 !== 8'h3C || V1 !== 1'b1 || CNT !== 8'd3) begin
      bad++; $display("FAIL bp_accept got=Y1 %h V1 %b CNT %0d want=3c 1 3", Y1, V1, CNT);
    end
  endtask

  task automatic test_passthrough();
    int c0;
    step(1'b0, 8'hEE, 2'd3, 1'b1, 4'h0);
    c0 = m_cnt;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'(i), 2'd3, 1'b1, 4'b1000);
      total++;
      if (obs_ready !== 1'b1 || V3 !== 1'b1 || Y3 !== 8'(i)) begin
        bad++; $display("FAIL pass_%0d got=rdy %b V3 %b Y3 %h want=1 1 %h", i, obs_ready, V3, Y3, 8'(i));
      end
    end
    total++;
    if (CNT !== 8'((c0 + 10) % 256)) begin bad++; $display("FAIL pass_cnt got=%0d want=%0d", CNT, (c0 + 10) % 256); end
  endtask

  task automatic test_drain_all();
    step(1'b1, 8'h00, 2'd0, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) step(1'b0, 8'(8'h10 + k), 2'(k), 1'b1, 4'h0);
    total++;
    if (v_obs !== 4'hF) begin bad++; $display("FAIL drain_fill got=%b want=1111", v_obs); end
    step(1'b0, 8'h99, 2'd0, 1'b0, 4'hF);
    total++;
    if (v_obs !== 4'h0) begin bad++; $display("FAIL drain_v got=%b want=0000", v_obs); end
    total++;
    if (CNT !== 8'd4) begin bad++; $display("FAIL drain_cnt got=%0d want=4", CNT); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (y_obs[k] !== 8'(8'h10 + k)) begin bad++; $display("FAIL drain_y%0d got=%h want=%h", k, y_obs[k], 8'(8'h10 + k)); end
    end
  endtask

  task automatic test_wrap_and_reset();
    int stalls = 0;
    step(1'b1, 8'h00, 2'd0, 1'b0, 4'h0);
    for (int i = 0; i < 252; i++) begin
      step(1'b0, 8'($urandom), 2'($urandom_range(0, 3)), 1'b1, 4'hF);
      if (obs_ready !== 1'b1) stalls++;
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'(8'hC0 + k), 2'(k), 1'b1, 4'(1 << k));
      if (obs_ready !== 1'b1) stalls++;
    end
    total++;
    if (stalls != 0) begin bad++; $display("FAIL wrap_stalls got=%0d want=0", stalls); end
    total++;
    if (CNT !== 8'd0) begin bad++; $display("FAIL wrap_cnt got=%0d want=0", CNT); end
    total++;
    if (v_obs !== 4'hF) begin bad++; $display("FAIL wrap_v got=%b want=1111", v_obs); end
    step(1'b1, 8'h77, 2'd2, 1'b1, 4'h0);
    total++;
    if (obs_ready !== 1'b0) begin bad++; $display("FAIL rst_full_ready got=%b want=0", obs_ready); end
    total++;
    if (v_obs !== 4'h0 || CNT !== 8'd0 || Y0 !== 8'h00 || Y1 !== 8'h00 || Y2 !== 8'h00 || Y3 !== 8'h00) begin
      bad++; $display("FAIL rst_full_state got=V %b CNT %0d Y %h %h %h %h want=0000 0 00 00 00 00",
                      v_obs, CNT, Y0, Y1, Y2, Y3);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 8'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom), 4'($urandom));
      if (obs_ready !== exp_ready || v_obs !== m_v || CNT !== 8'(m_cnt) ||
          Y0 !== m_y[0] || Y1 !== m_y[1] || Y2 !== m_y[2] || Y3 !== m_y[3]) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_%0d got=rdy %b V %b CNT %0d Y %h %h %h %h want=rdy %b V %b CNT %0d Y %h %h %h %h",
                   i, obs_ready, v_obs, CNT, Y0, Y1, Y2, Y3,
                   exp_ready, m_v, m_cnt, m_y[0], m_y[1], m_y[2], m_y[3]);
      end
    end
    total++;
    if (errs != 0) bad++;
  endtask

  initial begin
    rst = 1'b1; D = '0; {S1, S0} = 2'd0; in_valid = 1'b0; {R3, R2, R1, R0} = 4'h0;
    m_v = 4'h0; m_cnt = 0;
    for (int k = 0; k < 4; k++) m_y[k] = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_passthrough();
    test_drain_all();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
